// File: rtl/acl_tilt_filter.sv
// Accelerometer X-axis tilt filter: windowed average of signed 5-bit samples,
// hysteretic CENTER/LEFT/RIGHT classification and a no-sample staleness timeout.
module acl_tilt_filter #(
    parameter int AVG_LOG2   = 2,
    parameter int ON_THRESH  = 3,
    parameter int OFF_THRESH = 1,
    parameter int TIMEOUT    = 4000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [14:0]       acl_data,
    input  logic              sample_valid,
    output logic              tilt_left,
    output logic              tilt_right,
    output logic [3:0]        tilt_intensity,
    output logic signed [4:0] x_avg,
    output logic              avg_valid,
    output logic              stale
);

    localparam int ACC_W  = 5 + AVG_LOG2;
    localparam int CNT_W  = AVG_LOG2 + 1;
    localparam int IDLE_W = $clog2(TIMEOUT + 1);

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'((1 << AVG_LOG2) - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(TIMEOUT);

    typedef enum logic [1:0] {
        CENTER = 2'd0,
        LEFT   = 2'd1,
        RIGHT  = 2'd2
    } state_t;

    state_t                    r_state;
    state_t                    w_state_next;
    logic signed [ACC_W-1:0]   r_acc;
    logic signed [ACC_W-1:0]   r_sum;
    logic [CNT_W-1:0]          r_cnt;
    logic [IDLE_W-1:0]         r_idle;
    logic                      r_eval;

    logic signed [ACC_W-1:0]   w_sample;
    logic signed [ACC_W-1:0]   w_acc_sum;
    logic signed [4:0]         w_avg;
    int                        w_avg_i;
    logic [3:0]                w_mag;
    logic                      w_close;
    logic                      w_timeout;
    logic                      w_unused_acl;

    assign w_unused_acl = ^{acl_data[14:10], acl_data[4:0]};

    assign w_sample  = ACC_W'(signed'(acl_data[9:5]));
    assign w_acc_sum = r_acc + w_sample;
    assign w_close   = sample_valid && (r_cnt == CNT_LAST);
    // Timeout fires on the edge where the idle count would reach TIMEOUT.
    assign w_timeout = !sample_valid && (r_idle == IDLE_LAST);

    assign w_avg   = 5'(r_sum >>> AVG_LOG2);
    assign w_avg_i = int'(w_avg);
    assign w_mag   = (w_avg == 5'sb10000) ? 4'd15 :
                     w_avg[4]             ? 4'(-w_avg) : 4'(w_avg);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc  <= '0;
            r_cnt  <= '0;
            r_sum  <= '0;
            r_eval <= 1'b0;
            r_idle <= '0;
        end else begin
            r_eval <= w_close;
            if (sample_valid) begin
                r_idle <= '0;
            end else if (r_idle != IDLE_MAX) begin
                r_idle <= r_idle + IDLE_W'(1);
            end
            if (w_timeout) begin
                r_acc <= '0;
                r_cnt <= '0;
            end else if (sample_valid) begin
                if (w_close) begin
                    r_acc <= '0;
                    r_cnt <= '0;
                    r_sum <= w_acc_sum;
                end else begin
                    r_acc <= w_acc_sum;
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= CENTER;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: the default assignment first keeps this block free of latches.
    always_comb begin
        w_state_next = r_state;
        if (w_timeout) begin
            w_state_next = CENTER;
        end else if (r_eval) begin
            case (r_state)
                CENTER: begin
                    if (w_avg_i >= ON_THRESH)       w_state_next = LEFT;
                    else if (w_avg_i <= -ON_THRESH) w_state_next = RIGHT;
                end
                LEFT: begin
                    if (w_avg_i <= -ON_THRESH)      w_state_next = RIGHT;
                    else if (w_avg_i < OFF_THRESH)  w_state_next = CENTER;
                end
                RIGHT: begin
                    if (w_avg_i >= ON_THRESH)       w_state_next = LEFT;
                    else if (w_avg_i > -OFF_THRESH) w_state_next = CENTER;
                end
                default: w_state_next = CENTER;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tilt_left      <= 1'b0;
            tilt_right     <= 1'b0;
            tilt_intensity <= '0;
            x_avg          <= '0;
            avg_valid      <= 1'b0;
            stale          <= 1'b1;
        end else begin
            avg_valid <= 1'b0;
            if (w_timeout) begin
                tilt_left      <= 1'b0;
                tilt_right     <= 1'b0;
                tilt_intensity <= '0;
                x_avg          <= '0;
                stale          <= 1'b1;
            end else begin
                if (sample_valid) begin
                    stale <= 1'b0;
                end
                if (r_eval) begin
                    x_avg          <= w_avg;
                    tilt_left      <= (w_state_next == LEFT);
                    tilt_right     <= (w_state_next == RIGHT);
                    tilt_intensity <= (w_state_next == CENTER) ? 4'd0 : w_mag;
                    avg_valid      <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_acl_tilt_filter.sv
// Scoreboard bench for acl_tilt_filter: directed windows push expected records,
// a negedge monitor pops one record per avg_valid pulse.
module tb_acl_tilt_filter;

    logic              clk;
    logic              rst_n;
    logic [14:0]       acl_data;
    logic              sample_valid;
    logic              tilt_left;
    logic              tilt_right;
    logic [3:0]        tilt_intensity;
    logic signed [4:0] x_avg;
    logic              avg_valid;
    logic              stale;

    int n_cmp = 0;
    int n_err = 0;

    // Record layout: {x_avg[4:0], tilt_left, tilt_right, tilt_intensity[3:0], stale}
    logic [11:0] sb[$];

    acl_tilt_filter #(
        .AVG_LOG2   (2),
        .ON_THRESH  (3),
        .OFF_THRESH (1),
        .TIMEOUT    (64)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .acl_data       (acl_data),
        .sample_valid   (sample_valid),
        .tilt_left      (tilt_left),
        .tilt_right     (tilt_right),
        .tilt_intensity (tilt_intensity),
        .x_avg          (x_avg),
        .avg_valid      (avg_valid),
        .stale          (stale)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [11:0] rec(input int x, input logic l, input logic r,
                                        input int i, input logic s);
        return {5'(x), l, r, 4'(i), s};
    endfunction

    function automatic logic [11:0] dut_rec();
        return {x_avg, tilt_left, tilt_right, tilt_intensity, stale};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && avg_valid === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_avg_valid: got record 0x%0h, expected no pulse (t=%0t)",
                         dut_rec(), $time);
            end else begin
                check("window_record", 32'(dut_rec()), 32'(sb.pop_front()));
            end
        end
    end

    task automatic send(input int x);
        @(posedge clk); #1;
        sample_valid = 1'b1;
        acl_data     = {5'($urandom), 5'(x), 5'($urandom)};
    endtask

    task automatic idle_one();
        @(posedge clk); #1;
        sample_valid = 1'b0;
        acl_data     = 15'($urandom);
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 4 && sb.size() != 0; k++) @(posedge clk);
        #1;
        check(name, 32'(sb.size()), 32'd0);
    endtask

    task automatic window(input int a, input int b, input int c, input int d,
                          input logic [11:0] exp, input string name);
        sb.push_back(exp);
        send(a); send(b); send(c); send(d);
        idle_one();
        drain(name);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n        = 1'b1;
        sample_valid = 1'b0;
        acl_data     = '0;
        #1 rst_n = 1'b0;
        #1;
        check("reset_record", 32'(dut_rec()), 32'(rec(0, 0, 0, 0, 1)));
        check("reset_avg_valid", 32'(avg_valid), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("stale_after_reset", 32'(dut_rec()), 32'(rec(0, 0, 0, 0, 1)));

        // +5 window with explicit latency check
        sb.push_back(rec(5, 1, 0, 5, 0));
        send(5); send(5); send(5); send(5);
        idle_one();
        @(negedge clk);
        check("latency_capture_edge", 32'(avg_valid), 32'd0);
        @(negedge clk);
        check("latency_next_edge", 32'(avg_valid), 32'd1);
        drain("drain_plus5");

        window(2, 2, 2, 2,   rec(2, 1, 0, 2, 0),    "drain_left_hold");
        window(0, 0, 0, 0,   rec(0, 0, 0, 0, 0),    "drain_left_to_center");
        window(3, 3, 3, -1,  rec(2, 0, 0, 0, 0),    "drain_center_hold");
        window(3, 3, 3, 3,   rec(3, 1, 0, 3, 0),    "drain_center_on_edge");
        window(-8, -8, -8, -8,     rec(-8, 0, 1, 8, 0),   "drain_left_to_right");
        window(-16, -16, -16, -16, rec(-16, 0, 1, 15, 0), "drain_saturate");
        window(-1, 0, 0, 0,  rec(-1, 0, 1, 1, 0),   "drain_floor_round");

        // Partial window, then timeout from RIGHT
        send(-16); send(-16);
        idle_one();
        repeat (63) @(posedge clk);
        @(negedge clk);
        check("pre_timeout_hold", 32'(dut_rec()), 32'(rec(-1, 0, 1, 1, 0)));
        @(negedge clk);
        check("timeout_forced", 32'(dut_rec()), 32'(rec(0, 0, 0, 0, 1)));
        repeat (5) @(negedge clk);
        check("timeout_stays_stale", 32'(dut_rec()), 32'(rec(0, 0, 0, 0, 1)));

        // Fresh window after timeout; first capture clears stale
        sb.push_back(rec(5, 1, 0, 5, 0));
        send(5);
        @(negedge clk);
        check("stale_before_capture", 32'(stale), 32'd1);
        send(5);
        check("stale_cleared", 32'(stale), 32'd0);
        send(5); send(5);
        idle_one();
        drain("drain_after_timeout");

        // Sample arriving in the avg_valid cycle starts the next window
        sb.push_back(rec(2, 1, 0, 2, 0));
        send(2); send(2); send(2); send(2);
        idle_one();
        sb.push_back(rec(-8, 0, 1, 8, 0));
        send(-8);
        check("overlap_cycle", 32'(avg_valid), 32'd1);
        send(-8); send(-8); send(-8);
        idle_one();
        drain("drain_overlap_window");

        // Reset mid-window discards the partial sum
        send(5); send(5);
        idle_one();
        #3 rst_n = 1'b0;
        #1;
        check("async_reset_record", 32'(dut_rec()), 32'(rec(0, 0, 0, 0, 1)));
        check("async_reset_avg_valid", 32'(avg_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        window(15, 15, 15, 15, rec(15, 1, 0, 15, 0), "drain_after_reset");

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/acl_tilt_filter.md
ACL_TILT_FILTER -- requirements
Module: acl_tilt_filter

Interface
REQ-001 Parameter AVG_LOG2, default 2, log2 of the number of samples averaged per window (window = 4 samples).
REQ-002 Parameter ON_THRESH, default 3, minimum averaged magnitude to enter a tilt state.
REQ-003 Parameter OFF_THRESH, default 1, averaged magnitude below which a tilt state is left.
REQ-004 Parameter TIMEOUT, default 4000000, number of clk cycles without a sample before the outputs are forced stale.
REQ-005 Port: clk  in  1  single clock for the block (4 MHz SPI clock domain).
REQ-006 Port: rst_n  in  1  reset, asynchronous, active-low.
REQ-007 Port: acl_data  in  15  accelerometer word from spi_master; bits [9:5] are X axis, signed two's complement 5-bit.
REQ-008 Port: sample_valid  in  1  one-cycle pulse; acl_data holds a new sample in that cycle.
REQ-009 Port: tilt_left  out  1  filtered left tilt (positive X).
REQ-010 Port: tilt_right  out  1  filtered right tilt (negative X).
REQ-011 Port: tilt_intensity  out  4  filtered tilt magnitude, 0 when centred.
REQ-012 Port: x_avg  out  5  signed windowed X average.
REQ-013 Port: avg_valid  out  1  one-cycle pulse when x_avg and tilt outputs update.
REQ-014 Port: stale  out  1  high while no sample has arrived within TIMEOUT cycles, or since reset.

Function
REQ-015 Capture: on a clk edge with sample_valid=1, the block SHALL add sign-extended acl_data[9:5] to a (5+AVG_LOG2)-bit signed accumulator and increment the sample count; other acl_data bits are ignored.
REQ-016 Window close: on capture of sample 2^AVG_LOG2, the accumulator and count SHALL clear on that same edge, and the block SHALL latch the new sum for evaluation.
REQ-017 Average: x_avg SHALL equal sum arithmetically shifted right by AVG_LOG2 (rounds toward negative infinity), range -16..15.
REQ-018 Latency: x_avg, tilt_left, tilt_right, tilt_intensity and the avg_valid pulse SHALL update on the edge one cycle after the window-closing capture edge.
REQ-019 Magnitude: mag = |x_avg|; -16 SHALL saturate to 15.
REQ-020 FSM states: CENTER, LEFT, RIGHT; transitions are evaluated only on window close; exactly one of tilt_left/tilt_right is high in LEFT/RIGHT, and both are low in CENTER.
REQ-021 CENTER: go LEFT if x_avg >= ON_THRESH; go RIGHT if x_avg <= -ON_THRESH; otherwise stay.
REQ-022 LEFT: go RIGHT if x_avg <= -ON_THRESH; go CENTER if x_avg < OFF_THRESH; otherwise stay. RIGHT mirrors this with the signs swapped.
REQ-023 tilt_intensity SHALL equal mag of the evaluated window when the next state is LEFT/RIGHT, and 0 when the next state is CENTER.
REQ-024 Timeout: the idle counter SHALL clear on every sample_valid and otherwise increment, saturating at TIMEOUT.
REQ-025 When the idle counter reaches TIMEOUT, on that edge: state SHALL go to CENTER, tilt outputs and x_avg SHALL go to 0, the accumulator and count SHALL clear, stale SHALL go to 1, and no avg_valid pulse SHALL be produced.
REQ-026 stale SHALL clear on the edge capturing the next sample_valid; that sample starts a fresh window.
REQ-027 A sample_valid arriving in the avg_valid cycle SHALL be captured normally as the first sample of the next window.
REQ-028 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-029 rst_n=0 SHALL immediately, without waiting for clk, force: state CENTER, accumulator 0, count 0, idle counter 0, tilt_left=0, tilt_right=0, tilt_intensity=0, x_avg=0, avg_valid=0, stale=1.
REQ-030 Reset asserted mid-window SHALL discard the partial window; after release, a full 2^AVG_LOG2 new samples are required before avg_valid.

Verification (AVG_LOG2=2, ON=3, OFF=1, TIMEOUT=64)
REQ-031 Four samples X=+5 (acl_data[9:5]=00101) -> avg_valid pulses one cycle after the 4th capture; x_avg=5, tilt_left=1, intensity=5, stale=0.
REQ-032 From LEFT: window of +2 -> stays LEFT, intensity=2; then window of 0 -> CENTER, intensity=0. From CENTER: window 3,3,3,-1 (sum 8, avg 2) -> stays CENTER.
REQ-033 From LEFT: window of -8 (11000) -> tilt_right=1, tilt_left=0, intensity=8 directly; window of -16 (10000) -> intensity=15.
REQ-034 In RIGHT with no sample_valid for 64 cycles -> CENTER, all tilt outputs 0, stale=1, no avg_valid; next sample clears stale.
REQ-035 Two samples captured, then rst_n pulsed low mid-cycle -> outputs reset asynchronously; avg_valid appears only after 4 further samples.
REQ-036 sample_valid asserted in the avg_valid cycle of window N -> counted in window N+1; window N+1 closes after 3 more samples.
